// File: rtl/serial_magnitude_comparator_pkg.sv
// magcmp_pkg: shared types and helpers for the serial magnitude comparator
// Contents: cmp_state_t (FSM state), cmp_result_t (g/e/s flags), cnt_width (digit counter width)
package magcmp_pkg;

    typedef enum logic [0:0] {IDLE, RUN} cmp_state_t;

    typedef struct packed {
        logic g;
        logic e;
        logic s;
    } cmp_result_t;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_magnitude_comparator_if.sv
// serial_magnitude_comparator_if: start/busy/done handshake, operands and result flags
// Signals:
//   start, signed_mode, a, b  requester -> comparator
//   busy, done, g, e, s       comparator -> requester
// Modports: master (requester), slave (comparator)
interface serial_magnitude_comparator_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             g;
    logic             e;
    logic             s;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, g, e, s
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, g, e, s
    );

endinterface

// File: rtl/serial_magnitude_comparator_digit_comparator.sv
// digit_comparator: combinational g/e/s compare of two DIGIT-bit unsigned slices
// Ports:
//   x, y  in   DIGIT-bit slices
//   r     out  result flags (x>y, x==y, x<y)
module digit_comparator
    import magcmp_pkg::*;
#(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    output cmp_result_t      r
);

    always_comb begin
        r.g = x > y;
        r.e = x == y;
        r.s = x < y;
    end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator: multi-cycle MSB-first magnitude compare, DIGIT bits per clock
// Ports:
//   clk  in  clock, rising edge
//   rst  in  asynchronous reset, active-high
//   bus  slave modport: start/signed_mode/a/b in, busy/done/g/e/s out
// Config macro CMP_EARLY_TERM_EN: leave RUN on the first differing digit instead of after all N digits.
module serial_magnitude_comparator
    import magcmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input logic                        clk,
    input logic                        rst,
    serial_magnitude_comparator_if.slave bus
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);

    cmp_state_t       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             decided;
    logic             done;
    cmp_result_t      first;
    cmp_result_t      res;
    cmp_result_t      dr;
    cmp_result_t      fin;
    logic             last;
    logic             term;

    digit_comparator #(.DIGIT(DIGIT)) u_digit (
        .x(sa[WIDTH-1 -: DIGIT]),
        .y(sb[WIDTH-1 -: DIGIT]),
        .r(dr)
    );

    // Until a difference is seen the live digit result is either "equal so far" or the decision itself.
    always_comb begin
        last = cnt == CW'(N - 1);
        fin  = decided ? first : dr;
`ifdef CMP_EARLY_TERM_EN
        term = last || !dr.e;
`else
        term = last;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            sa      <= '0;
            sb      <= '0;
            decided <= 1'b0;
            first   <= '0;
            res     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    // Flipping the sign bit maps two's-complement order onto unsigned order.
                    sa      <= bus.a ^ {bus.signed_mode, {(WIDTH-1){1'b0}}};
                    sb      <= bus.b ^ {bus.signed_mode, {(WIDTH-1){1'b0}}};
                    cnt     <= '0;
                    decided <= 1'b0;
                    state   <= RUN;
                end
            end else begin
                sa  <= sa << DIGIT;
                sb  <= sb << DIGIT;
                cnt <= cnt + CW'(1);
                if (!decided && !dr.e) begin
                    decided <= 1'b1;
                    first   <= dr;
                end
                if (term) begin
                    res   <= fin;
                    done  <= 1'b1;
                    state <= IDLE;
                end
            end
        end
    end

    assign bus.busy = state == RUN;
    assign bus.done = done;
    assign bus.g    = res.g;
    assign bus.e    = res.e;
    assign bus.s    = res.s;

endmodule
